// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Target end of the datapath load/store interface. Accepts one request at a
//   time, waits LATENCY cycles, performs an RV32I byte/half/word access on a
//   word-organised byte-addressed store, then holds the response until the
//   initiator takes it.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (state, response and storage)
//   req_valid  request present            req_ready  responder idle, can accept
//   req_write  1 = store, 0 = load        req_funct3 RV32I access size/sign
//   req_addr   byte address               req_wdata  store data (low lanes used)
//   rsp_valid  response present           rsp_ready  initiator takes response
//   rsp_rdata  extended load data (0 for stores and errors)
//   rsp_err    misaligned access or illegal funct3
module data_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int         WIDX_W   = DM_ADDRESS - 2;
  localparam int         WORDS    = 2 ** WIDX_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       capture, commit;

  logic                  write_p0;
  logic [2:0]            funct3_p0;
  logic [DM_ADDRESS-1:0] addr_p0;
  logic [DATA_W-1:0]     wdata_p0;

  logic [DATA_W-1:0] mem [WORDS];

  logic [WIDX_W-1:0] word_idx;
  logic [DATA_W-1:0] rd_word, ld_data, st_word;
  logic              acc_err;

  // Illegal funct3 or an address not aligned to the access size.
  function automatic logic access_err(input logic w, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic illegal, mis;
    illegal = w ? (f3 > 3'b010) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    mis     = ((f3[1:0] == 2'b01) && off[0]) ||
              ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || mis;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  // Assigning a narrower signed value to a wider signed one sign-extends.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] off);
    logic        [DATA_W-1:0] sh;
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] ext;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  ext = b;
      3'b001:  ext = h;
      3'b010:  ext = sh;
      3'b100:  ext = {{(DATA_W-8){1'b0}}, sh[7:0]};
      3'b101:  ext = {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: ext = '0;
    endcase
    return ext;
  endfunction

  // Replicate store data across lanes and merge only the enabled bytes.
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] wd,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] off);
    logic [3:0]        be;
    logic [DATA_W-1:0] data, mask;
    case (f3[1:0])
      2'b00:   begin be = 4'b0001 << off; data = {4{wd[7:0]}};  end
      2'b01:   begin be = 4'b0011 << off; data = {2{wd[15:0]}}; end
      2'b10:   begin be = 4'b1111;        data = wd;            end
      default: begin be = 4'b0000;        data = '0;            end
    endcase
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
    return (old & ~mask) | (data & mask);
  endfunction

  // Control: state and latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture   = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: captured request, held for the whole BUSY period
  always_ff @(posedge clk) begin
    if (capture) begin
      write_p0  <= req_write;
      funct3_p0 <= req_funct3;
      addr_p0   <= req_addr;
      wdata_p0  <= req_wdata;
    end
  end

  assign word_idx = addr_p0[DM_ADDRESS-1:2];
  assign rd_word  = mem[word_idx];
  assign acc_err  = access_err(write_p0, funct3_p0, addr_p0[1:0]);
  assign ld_data  = load_extend(rd_word, funct3_p0, addr_p0[1:0]);
  assign st_word  = store_merge(rd_word, wdata_p0, funct3_p0, addr_p0[1:0]);

  // Commit: storage write and response registers update at BUSY->RESP only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (commit && write_p0 && !acc_err) begin
      mem[word_idx] <= st_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= acc_err;
      rsp_rdata <= (acc_err || write_p0) ? '0 : ld_data;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem_m [512];

  data_mem_responder #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference: byte-array memory, little-endian, size from funct3.
  task automatic model(input logic w, input logic [2:0] f3, input int a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int     size;
    bit     legal;
    longint v;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    legal = w ? (f3 <= 3'd2) : (size != 0);
    er = !legal;
    if (legal && (a % size) != 0) er = 1'b1;
    rd = '0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < size; i++) mem_m[a+i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (longint'(mem_m[a+i]) << (8*i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8*size));
        rd = v[31:0];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 512; i++) mem_m[i] = 8'h00;
  endtask

  // One complete handshake; lat counts cycles from the accept edge to rsp_valid.
  task automatic xact(input logic w, input logic [2:0] f3, input logic [8:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [8:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output logic [31:0] exp_rd, output logic exp_er);
    model(w, f3, int'(a), wd, exp_rd, exp_er);
    xact(w, f3, a, wd, rd, er, lat);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  task automatic test_directed();
    vec_t        tbl[13];
    logic [31:0] rd, xrd;
    logic        er, xer;
    int          lat;
    tbl[0]  = '{1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 3'b000, 9'h013, 32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[3]  = '{1'b0, 3'b100, 9'h013, 32'h0,        32'h000000DE, 1'b0};
    tbl[4]  = '{1'b0, 3'b001, 9'h012, 32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[5]  = '{1'b0, 3'b101, 9'h010, 32'h0,        32'h0000BEEF, 1'b0};
    tbl[6]  = '{1'b1, 3'b000, 9'h011, 32'h00000055, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b0, 3'b010, 9'h010, 32'h0,        32'hDEAD55EF, 1'b0};
    tbl[8]  = '{1'b0, 3'b010, 9'h012, 32'h0,        32'h00000000, 1'b1};
    tbl[9]  = '{1'b1, 3'b001, 9'h011, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[10] = '{1'b0, 3'b010, 9'h010, 32'h0,        32'hDEAD55EF, 1'b0};
    tbl[11] = '{1'b0, 3'b011, 9'h010, 32'h0,        32'h00000000, 1'b1};
    tbl[12] = '{1'b1, 3'b100, 9'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, rd, er, lat, xrd, xer);
      n_checks++;
      if (rd !== tbl[i].rd || er !== tbl[i].er) begin
        n_errors++;
        $display("FAIL directed[%0d]: rdata=%h err=%b, required %h %b", i, rd, er, tbl[i].rd, tbl[i].er);
      end
      n_checks++;
      if (lat != LAT + 1) begin
        n_errors++;
        $display("FAIL directed_latency[%0d]: %0d cycles, required %0d", i, lat, LAT + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] xrd, rd;
    logic        xer, er;
    int          n, lat;
    model(1'b0, 3'b010, 32'h010, 32'h0, xrd, xer);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 9'h010; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== xrd || rsp_err !== xer) begin
      n_errors++;
      $display("FAIL stall_first: valid=%b rdata=%h err=%b, required 1 %h %b", rsp_valid, rsp_rdata, rsp_err, xrd, xer);
    end
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 9'h040; req_wdata = 32'hFFFFFFFF;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== xrd || rsp_err !== xer || req_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, xrd, xer);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_release: ready=%b valid=%b, required 1 0", req_ready, rsp_valid);
    end
    // The stores presented during the stall must not have landed.
    issue(1'b0, 3'b010, 9'h040, 32'h0, rd, er, lat, xrd, xer);
    n_checks++;
    if (rd !== xrd || er !== xer) begin
      n_errors++;
      $display("FAIL stall_ignored_store: rdata=%h err=%b, required %h %b", rd, er, xrd, xer);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, xrd, wd;
    logic        er, xer, w;
    logic [2:0]  f3;
    logic [8:0]  a;
    int          lat;
    for (int i = 0; i < 80; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) < 8) ? (w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)))
                                      : 3'($urandom_range(0, 7));
      a  = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      a[8:6] = 3'b000;
      wd = $urandom;
      issue(w, f3, a, wd, rd, er, lat, xrd, xer);
      n_checks++;
      if (rd !== xrd || er !== xer) begin
        n_errors++;
        $display("FAIL random[%0d] w=%b f3=%b a=%h: rdata=%h err=%b, required %h %b",
                 i, w, f3, a, rd, er, xrd, xer);
      end
      n_checks++;
      if (lat != LAT + 1) begin
        n_errors++;
        $display("FAIL random_latency[%0d]: %0d cycles, required %0d", i, lat, LAT + 1);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, xrd;
    logic        er, xer;
    int          n, lat;
    // Reset one cycle into BUSY of a store: no write, outputs back to reset values.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 9'h020; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    issue(1'b0, 3'b010, 9'h020, 32'h0, rd, er, lat, xrd, xer);
    n_checks++;
    if (rd !== 32'h00000000 || er !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy_nowrite: rdata=%h err=%b, required 00000000 0", rd, er);
    end
    // Store then load it back, and drop that load's response with reset in RESP.
    issue(1'b1, 3'b010, 9'h024, 32'hA5A5F00D, rd, er, lat, xrd, xer);
    model(1'b0, 3'b010, 32'h024, 32'h0, xrd, xer);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 9'h024;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== xrd) begin
      n_errors++;
      $display("FAIL raw_before_reset: valid=%b rdata=%h, required 1 %h", rsp_valid, rsp_rdata, xrd);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_resp: valid=%b rdata=%h ready=%b, required 0 00000000 1",
               rsp_valid, rsp_rdata, req_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the load/store interface driven by the single-cycle datapath.
- Accepts one load/store request at a time over a valid/ready handshake.
- Performs RV32I byte, half and word access with sign/zero extension and misalignment checking.
- Returns one response per request over a second valid/ready handshake after a programmable latency.
- Sits between the datapath (alu_result as address, reg2 as store data, funct3 as access size) and byte-addressed storage.

Parameters:
DATA_W, 32, data width; fixed at 32 for byte-lane logic
DM_ADDRESS, 9, byte-address width; storage = 2**DM_ADDRESS bytes = 128 words
LATENCY, 2, cycles spent in BUSY before the response; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  access size: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw
req_addr  input  DM_ADDRESS  byte address
req_wdata  input  DATA_W  store data; the low byte/half/word is used
rsp_valid  output  1  response present
rsp_ready  input  1  initiator accepts the response
rsp_rdata  output  DATA_W  load data, extended to 32 bits; 0 for stores and errors
rsp_err  output  1  misaligned or illegal funct3

Behaviour:
- Reset (reset=0, asynchronous), effective immediately:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - All storage words cleared to 0.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. If req_valid=1 at a clock edge, capture write/funct3/addr/wdata, load counter with LATENCY-1, go to BUSY.
  - BUSY: req_ready=0. Counter decrements each cycle. At the edge where counter==0, perform the access, register the results into rsp_rdata/rsp_err, go to RESP.
  - RESP: rsp_valid=1, outputs held stable. When rsp_ready=1 at an edge, go to IDLE and clear rsp_valid.
- Latency: from the accept edge to the first rsp_valid=1 cycle is exactly LATENCY+1 cycles.
  - Example, LATENCY=2: accept at edge 0; rsp_valid high after edge 2.
- A new request cannot be accepted in the same cycle a response is consumed. req_ready rises the cycle after the RESP->IDLE transition.
- Error checks, evaluated on the captured request:
  - Half access with addr[0]=1 → misaligned.
  - Word access with addr[1:0]!=0 → misaligned.
  - Load funct3 ∈ {011, 110, 111} → illegal.
  - Store funct3 ∉ {000, 001, 010} → illegal.
  - On error: rsp_err=1, rsp_rdata=0, storage unchanged.
- Load lane selection:
  - Word index = addr[DM_ADDRESS-1:2].
  - lb/lbu select the byte at addr[1:0].
  - lh/lhu select the half at addr[1].
  - lb/lh sign-extend bit 7/15; lbu/lhu zero-extend.
- Store: write only the selected byte lanes (byte-enable); other lanes unchanged. rsp_rdata=0, rsp_err=0.
- Commit point: the storage write occurs only at the BUSY->RESP edge. Reset asserted while in BUSY aborts the request with no write.
- Reset while in RESP drops the response; rsp_valid=0 immediately.
- req_valid while not in IDLE is ignored. The initiator must hold its request until req_ready.
- Address wrap: none. req_addr spans storage exactly; every in-range aligned address is valid.
- Read-after-write: a load accepted after a store's response is consumed returns the new data.

Test Plan:
- Reset then sw addr 0x010 data 0xDEADBEEF, then lw 0x010 (LATENCY=2) → rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid rises exactly 3 cycles after each accept edge.
- After the above: lb 0x013 → 0xFFFFFFDE; lbu 0x013 → 0x000000DE; lh 0x012 → 0xFFFFDEAD; lhu 0x010 → 0x0000BEEF.
- sb 0x011 data 0x00000055, then lw 0x010 → 0xDEAD55EF (only lane 1 changed).
- lw 0x012 → rsp_err=1, rsp_rdata=0. sh 0x011 → rsp_err=1, and a following lw 0x010 shows the word unchanged. Load funct3=011 → rsp_err=1.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, extra req_valid pulses ignored. After rsp_ready=1, req_ready=1 the following cycle.
- Issue sw 0x020 data 0x12345678 and pulse reset low mid-BUSY (1 cycle after accept) → outputs return to reset values asynchronously. After release, lw 0x020 → 0x00000000.
